// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative unsigned multiply/divide unit:
// state encoding, operation select codes and sizing helpers.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Step counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the ALU (master) and the multiply/divide
// unit (slave).
interface muldiv_if #(
    parameter int WIDTH = muldiv_pkg::MULDIV_WIDTH
);
    logic                 valid;
    logic                 mode;
    logic [WIDTH-1:0]     in_A;
    logic [WIDTH-1:0]     in_B;
    logic                 ready;
    logic                 busy;
    logic [2*WIDTH-1:0]   out;

    modport master (
        output valid, mode, in_A, in_B,
        input  ready, busy, out
    );

    modport slave (
        input  valid, mode, in_A, in_B,
        output ready, busy, out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one
// shift register; one bit per cycle, fixed latency of WIDTH+3 cycles.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     op_q;      // multiplicand for MUL, divisor for DIV
    logic [2*WIDTH:0]     dp;        // shared P / {R,Q} register
    logic [2*WIDTH-1:0]   out_q;
    logic                 last_step;
    logic                 ready_d, busy_d;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH:0]     mul_next;
    logic [2*WIDTH:0]     div_shift;
    logic [WIDTH:0]       div_r;
    logic [2*WIDTH:0]     div_next;

    assign last_step = (cnt == CW'(WIDTH));

    // MUL keeps P in dp[2W:1] and DIV keeps {R,Q} in dp[2W:0], so every bit of
    // the shared register is used by one of the two algorithms.
    always_comb begin
        mul_sum  = {1'b0, dp[2*WIDTH:WIDTH+1]}
                 + (dp[1] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, dp[WIDTH:2], 1'b0};

        div_shift = {dp[2*WIDTH-1:0], 1'b0};
        div_r     = div_shift[2*WIDTH:WIDTH];
        div_next  = div_shift;
        if (div_r >= {1'b0, op_q}) begin
            div_next[2*WIDTH:WIDTH] = div_r - {1'b0, op_q};
            div_next[0]             = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        ready_d   = 1'b0;
        busy_d    = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.valid)
                    state_nxt = (bus.mode == MODE_DIV) ? ST_DIV : ST_MUL;
            end
            ST_MUL, ST_DIV: begin
                if (last_step) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ready_d   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op_q  <= '0;
            dp    <= '0;
            out_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid) begin
                        cnt <= '0;
                        if (bus.mode == MODE_DIV) begin
                            op_q <= bus.in_B;
                            dp   <= {{(WIDTH+1){1'b0}}, bus.in_A};
                        end else begin
                            op_q <= bus.in_A;
                            dp   <= {{WIDTH{1'b0}}, bus.in_B, 1'b0};
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (!last_step) begin
                        dp  <= (state == ST_MUL) ? mul_next : div_next;
                        cnt <= cnt + CW'(1);
                    end else begin
                        out_q <= (state == ST_DIV) ? dp[2*WIDTH-1:0]
                                                   : dp[2*WIDTH:1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = ready_d;
    assign bus.busy  = busy_d;
    assign bus.out   = out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: table-driven MUL/DIV vectors
// plus hand-written busy-isolation and mid-operation reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W       = 32;
    localparam int LATENCY = 34;   // negedges from sample edge to ready

    typedef struct {
        string        name;
        logic         mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic m,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
        int lat;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        bus.valid = 1'b1;
        bus.mode  = m;
        bus.in_A  = a;
        bus.in_B  = b;
        @(posedge clk);
        @(negedge clk);
        bus.valid = 1'b0;
        lat     = 1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < 100) begin
            if (bus.ready) seen = 1'b1;
            else begin
                if (!bus.busy) busy_ok = 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        check({name, " ready seen"}, 64'(seen), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(LATENCY));
        check({name, " busy while running"}, 64'(busy_ok && bus.busy), 64'd1);
        check({name, " out"}, bus.out, exp);
        @(negedge clk);
        check({name, " ready falls"}, 64'(bus.ready), 64'd0);
        check({name, " busy falls"}, 64'(bus.busy), 64'd0);
        check({name, " out holds"}, bus.out, exp);
    endtask

    vec_t vecs[$];

    initial begin
        int pulses;

        vecs.push_back('{"mul 3x5",      MODE_MUL, 32'd3,         32'd5,         64'h0000_0000_0000_000F});
        vecs.push_back('{"mul carry",    MODE_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
        vecs.push_back('{"mul 2^16sq",   MODE_MUL, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000});
        vecs.push_back('{"mul zero",     MODE_MUL, 32'd0,         32'h0000_0123, 64'h0});
        vecs.push_back('{"div 100/7",    MODE_DIV, 32'd100,       32'd7,         64'h0000_0002_0000_000E});
        vecs.push_back('{"div 7/100",    MODE_DIV, 32'd7,         32'd100,       64'h0000_0007_0000_0000});
        vecs.push_back('{"div by zero",  MODE_DIV, 32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF});
        vecs.push_back('{"div 0/0",      MODE_DIV, 32'd0,         32'd0,         64'h0000_0000_FFFF_FFFF});
        vecs.push_back('{"div max/1",    MODE_DIV, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF});
        vecs.push_back('{"div max/max",  MODE_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001});

        bus.valid = 1'b0;
        bus.mode  = MODE_MUL;
        bus.in_A  = '0;
        bus.in_B  = '0;

        repeat (3) @(negedge clk);
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset out", bus.out, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Busy isolation: operand, mode and valid changes mid-operation are ignored.
        @(negedge clk);
        bus.valid = 1'b1;
        bus.mode  = MODE_MUL;
        bus.in_A  = 32'd6;
        bus.in_B  = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.valid = 1'b1;
        bus.mode  = MODE_DIV;
        bus.in_A  = 32'd99;
        bus.in_B  = 32'd3;
        @(negedge clk);
        bus.valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                pulses++;
                if (pulses == 1) check("isolation out", bus.out, 64'd42);
            end
        end
        check("isolation ready pulses", 64'(pulses), 64'd1);
        check("isolation idle after", 64'(bus.busy), 64'd0);

        // Reset at step 10 of a DIV discards the partial result immediately.
        @(negedge clk);
        bus.valid = 1'b1;
        bus.mode  = MODE_DIV;
        bus.in_A  = 32'd1000;
        bus.in_B  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset ready", 64'(bus.ready), 64'd0);
        check("mid reset busy", 64'(bus.busy), 64'd0);
        check("mid reset out", bus.out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul 2x2 after reset", MODE_MUL, 32'd2, 32'd2, 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
